sr_ram_stream_reader: RTL and testbench

//  Read-side master for sr_sw_beh_ram: on a start command, it fetches LENGTH consecutive words from the RAM read port.

---
 rtl/sr_ram_stream_reader.sv | 127 ++++++++++++
 tb/tb_sr_ram_stream_reader.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sr_ram_stream_reader.sv
// Streams a run of consecutive RAM words (wrapping at DEPTH) onto a valid/ready port,
// hiding the RAM's one-cycle read latency behind a two-entry skid FIFO.
module sr_ram_stream_reader #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 4,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH     = ADDRESS_WIDTH + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_chip_select,
  output logic                     ram_read_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0]    ram_read_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_last
);

  // Stream handshake: a word transfers on every cycle where m_valid && m_ready;
  // m_valid never waits on m_ready, and m_data/m_last hold while stalled.

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                  state;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]     remaining;
  logic                     inflight;
  logic                     inflight_last;

  logic [DATA_WIDTH-1:0]    fifo_data [2];
  logic [1:0]               fifo_last;
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               fifo_count;

  logic                     pop;
  logic                     issue;
  logic [2:0]               occupancy;

  assign m_valid   = (fifo_count != 2'd0);
  assign m_data    = fifo_data[rd_ptr];
  assign m_last    = m_valid && fifo_last[rd_ptr];
  assign pop       = m_valid && m_ready;

  // Words already buffered or on their way, after this cycle's pop frees a slot.
  assign occupancy = 3'(fifo_count) + 3'(inflight) - 3'(pop);
  assign issue     = (state == FETCH) && (remaining != '0) && (occupancy < 3'd2);

  assign ram_read_enable = issue;
  assign ram_chip_select = issue;
  assign ram_read_addr   = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_WIDTH'(1));
      done          <= 1'b0;
      if (issue) begin
        addr      <= (addr == ADDRESS_WIDTH'(DEPTH - 1)) ? '0 : addr + ADDRESS_WIDTH'(1);
        remaining <= remaining - LEN_WIDTH'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              state     <= FETCH;
              addr      <= base_addr;
              remaining <= length;
              busy      <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue && (remaining == LEN_WIDTH'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) fifo_data[i] <= '0;
      fifo_last  <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= ram_read_data;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({inflight, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_ram_stream_reader.sv
// Bench for sr_ram_stream_reader: behavioural RAM, word-sequence reference model and
// per-cycle scoreboard covering directed cases and randomized transfers.
module tb_sr_ram_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] base_addr;
  logic [2:0] length;
  logic       busy;
  logic       done;
  logic       ram_chip_select;
  logic       ram_read_enable;
  logic [1:0] ram_read_addr;
  logic [7:0] ram_read_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [4];
  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [1:0] exp_addr_q[$];

  sr_ram_stream_reader #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .ram_chip_select(ram_chip_select),
    .ram_read_enable(ram_read_enable), .ram_read_addr(ram_read_addr),
    .ram_read_data(ram_read_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAM with one-cycle registered read
  initial ram_read_data = 8'h00;
  always @(posedge clk) begin
    if (ram_chip_select && ram_read_enable) ram_read_data <= mem[ram_read_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ram_cs"}, ram_chip_select, 0);
    check({tag, "_ram_re"}, ram_read_enable, 0);
    check({tag, "_ram_addr"}, ram_read_addr, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
  endtask

  function automatic logic pick_ready(input int mode, input int c);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ((c % 2) == 1);
    return ($urandom_range(0, 3) != 0);
  endfunction

  // mode: 0 ready always, 1 toggling, 2 random. inject_cycle: re-start attempt while busy.
  // abort_cycle: reset asserted in that cycle and the transfer abandoned.
  task automatic run(input int base, input int len, input int mode,
                     input int inject_cycle, input int abort_cycle);
    int  done_cycle = -1;
    bit  last_seen  = 0;
    bit  finished   = 0;
    int  issued     = 0;
    int  popped     = 0;
    bit  prev_stall = 0;
    logic [7:0] prev_data = '0;
    logic       prev_last = 0;
    int  limit      = 20 + 8 * len;
    exp_q.delete(); exp_last_q.delete(); exp_addr_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(mem[(base + i) % 4]);
      exp_last_q.push_back(i == len - 1);
      exp_addr_q.push_back(2'((base + i) % 4));
    end
    for (int c = 0; c <= limit && !finished; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        start = 1'b1; base_addr = 2'(base); length = 3'(len);
      end else if (c == inject_cycle) begin
        start = 1'b1; base_addr = 2'd3; length = 3'd4;
      end else begin
        start = 1'b0;
      end
      m_ready = pick_ready(mode, c);
      if (c == abort_cycle) begin
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        start = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("abort_no_done", done, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      check("busy", busy, (c >= 1) && !last_seen);
      check("done", done, (c == done_cycle));
      if (mode == 0) check("m_valid_timing", m_valid, (c >= 3) && (c < 3 + len));
      if (ram_read_enable) begin
        check("ram_cs", ram_chip_select, 1);
        if (exp_addr_q.size() == 0) check("extra_read", 1, 0);
        else check("ram_addr", ram_read_addr, exp_addr_q.pop_front());
        issued++;
      end
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_word", 1, 0);
        else begin
          check("m_data", m_data, exp_q.pop_front());
          check("m_last", m_last, exp_last_q.pop_front());
        end
        popped++;
        if (m_last) begin
          last_seen  = 1;
          done_cycle = c + 1;
        end
      end
      if (issued - popped > 2) check("outstanding", issued - popped, 2);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (c == done_cycle) finished = 1;
    end
    check("finished", finished, 1);
    check("words_left", exp_q.size(), 0);
    check("reads_left", exp_addr_q.size(), 0);
  endtask

  task automatic run_zero_len();
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      start = (c == 0); base_addr = 2'd0; length = 3'd0; m_ready = 1'b1;
      @(negedge clk);
      check("zl_busy", busy, 0);
      check("zl_ram_re", ram_read_enable, 0);
      check("zl_m_valid", m_valid, 0);
      check("zl_done", done, (c == 1));
    end
  endtask

  initial begin
    mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    run(0, 4, 0, -1, -1);   // full-rate stream
    run(2, 4, 0, -1, -1);   // wrap at DEPTH
    run(0, 6, 1, -1, -1);   // length > DEPTH with toggling backpressure
    run_zero_len();
    run(0, 4, 0, 2, -1);    // start while busy is ignored
    run(0, 4, 0, -1, 4);    // reset mid-transfer
    run(1, 2, 0, -1, -1);   // fresh start after reset

    for (int t = 0; t < 10; t++) begin
      run($urandom_range(0, 3), $urandom_range(1, 7), 2, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
